// File: rtl/fetch_queue_if.sv
// Bundle of the fetch front end's buses: redirect input, in-order
// instruction-memory request/response, and the (pc, instr) stream to decode.
// master = fetch_queue side, slave = surrounding pipeline / memory side.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;

  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_ready;

  logic [CW-1:0]   count;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  out_ready,
    output imem_req_valid, imem_req_addr,
    output out_valid, out_pc, out_instr, count
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output out_ready,
    input  imem_req_valid, imem_req_addr,
    input  out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, in-order imem request/response
// tracking and a DEPTH-entry (pc, instr) FIFO feeding decode. Requests are
// only issued when a FIFO slot is guaranteed for the response (credit rule),
// so responses never need backpressure. A redirect flushes the FIFO and
// turns every in-flight request into a response that must be discarded.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = CW + 2;

  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [XLEN-1:0] out_pc_reg, out_instr_reg;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [SW-1:0]   credit_used;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic            head_from_rsp;
  logic            head_from_mem;

  // Handshake qualifiers; redirect suppresses requests, pushes and pops.
  always_comb begin
    credit_used   = SW'(count_reg) + SW'(outstanding_reg) + SW'(drop_cnt_reg);
    req_valid     = !rst && !bus.redirect_valid && (credit_used < SW'(DEPTH));
    req_fire      = req_valid && bus.imem_req_ready;
    rsp_drop      = bus.imem_rsp_valid && (drop_cnt_reg != '0);
    push          = bus.imem_rsp_valid && (drop_cnt_reg == '0) && !bus.redirect_valid;
    pop           = (count_reg != '0) && bus.out_ready && !bus.redirect_valid;
    // The head register reloads from the incoming response when the entry
    // being written becomes the head, otherwise from the next stored entry.
    head_from_rsp = push && ((count_reg == '0) || (pop && count_reg == CW'(1)));
    head_from_mem = pop && (count_reg > CW'(1));
  end

  // Next-state for PCs, pointers and the occupancy/credit counters.
  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    count_next       = count_reg;
    outstanding_next = outstanding_reg;
    drop_cnt_next    = drop_cnt_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    if (bus.redirect_valid) begin
      fetch_pc_next    = bus.redirect_pc;
      rsp_pc_next      = bus.redirect_pc;
      count_next       = '0;
      wr_ptr_next      = '0;
      rd_ptr_next      = '0;
      outstanding_next = '0;
      drop_cnt_next    = drop_cnt_reg + outstanding_reg - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_next = fetch_pc_reg + XLEN'(PC_STEP);
      end
      if (push) begin
        rsp_pc_next = rsp_pc_reg + XLEN'(PC_STEP);
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      count_next       = count_reg + CW'(push) - CW'(pop);
      outstanding_next = outstanding_reg + CW'(req_fire) - CW'(push);
      drop_cnt_next    = drop_cnt_reg - CW'(rsp_drop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  // FIFO storage write; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= rsp_pc_reg;
      instr_mem[wr_ptr_reg] <= bus.imem_rsp_data;
    end
  end

  // Registered head entry; holds while stalled, empty or flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pc_reg    <= '0;
      out_instr_reg <= '0;
    end else if (head_from_rsp) begin
      out_pc_reg    <= rsp_pc_reg;
      out_instr_reg <= bus.imem_rsp_data;
    end else if (head_from_mem) begin
      out_pc_reg    <= pc_mem[rd_ptr_reg + AW'(1)];
      out_instr_reg <= instr_mem[rd_ptr_reg + AW'(1)];
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_reg;
  assign bus.out_valid      = (count_reg != '0);
  assign bus.out_pc         = out_pc_reg;
  assign bus.out_instr      = out_instr_reg;
  assign bus.count          = count_reg;

`ifndef SYNTHESIS
  // Protocol sanity: no unexpected response, no overflow, aligned redirect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.imem_rsp_valid && outstanding_reg == '0 && drop_cnt_reg == '0));
      assert (!(push && count_reg == CW'(DEPTH)));
      assert (!(bus.redirect_valid && (bus.redirect_pc % XLEN'(PC_STEP)) != '0));
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a behavioural memory model answers
// requests in order with configurable latency; the expected delivered stream
// is simply consecutive PCs from the last reset/redirect target with the
// memory word for each PC. A negedge monitor pops and compares on each
// accepted output.
module tb_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          CW       = $clog2(DEPTH + 1);
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  exp_t  exp_q[$];
  mreq_t mem_q[$];
  logic [31:0] next_exp_pc;

  int cyc = 0;
  int last_due = 0;
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int lat_min = 1, lat_max = 1;
  int req_rdy_pct = 100, out_rdy_pct = 100;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit coin(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{next_exp_pc, imem_word(next_exp_pc)});
      next_exp_pc += 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] base);
    exp_q.delete();
    next_exp_pc = base;
    refill();
  endtask

  // Start a cycle: random readiness and the memory model's response.
  task automatic step_mem();
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_req_ready = coin(req_rdy_pct);
    bus.out_ready      = coin(out_rdy_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = imem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
  endtask

  task automatic apply_ctrl(input bit r, input bit redir, input logic [31:0] tgt);
    rst                = r;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    if (r) begin
      mem_q.delete();
      last_due           = 0;
      bus.imem_rsp_valid = 1'b0;
      restart_stream(RESET_PC);
    end else if (redir) begin
      restart_stream(tgt);
    end
    refill();
  endtask

  task automatic cyc_step(input bit r = 1'b0, input bit redir = 1'b0, input logic [31:0] tgt = 32'h0);
    step_mem();
    apply_ctrl(r, redir, tgt);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
    check({tag, "_count"}, 32'(bus.count), 32'h0);
    check({tag, "_out_pc"}, bus.out_pc, 32'h0);
    check({tag, "_out_instr"}, bus.out_instr, 32'h0);
    check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'h0);
  endtask

  task automatic check_flushed(input string tag);
    @(negedge clk);
    check({tag, "_flush_valid"}, 32'(bus.out_valid), 32'h0);
    check({tag, "_flush_count"}, 32'(bus.count), 32'h0);
  endtask

  // Monitor: memory acceptance, invariants and scoreboard pops.
  always @(negedge clk) begin : monitor
    int   lat;
    int   due;
    exp_t e;
    if (!rst) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        lat = int'($urandom_range(lat_max, lat_min));
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{bus.imem_req_addr, due});
      end
      if (bus.redirect_valid)
        check("req_during_redirect", 32'(bus.imem_req_valid), 32'h0);
      check("valid_vs_count", 32'(bus.out_valid), 32'(bus.count != '0));
      if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty actual=pop required=none (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          $display("pop cyc=%0d pc=%h instr=%h exp_pc=%h", cyc, bus.out_pc, bus.out_instr, e.pc);
          check("out_pc", bus.out_pc, e.pc);
          check("out_instr", bus.out_instr, e.instr);
          pops++;
        end
      end
    end
  end

  initial begin
    int  waited;
    int  p0;
    bit  found;
    bit  redir;
    logic [31:0] tgt;

    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.out_ready      = 1'b0;
    restart_stream(RESET_PC);

    // Reset state
    repeat (3) cyc_step(1'b1);
    @(negedge clk);
    check_reset("reset");

    // Straight-line fetch, latency 1, always ready
    lat_min = 1; lat_max = 1; req_rdy_pct = 100; out_rdy_pct = 100;
    waited = 0;
    while (waited < 8) begin
      cyc_step();
      @(negedge clk);
      if (bus.out_valid) break;
      waited++;
    end
    check("first_valid_within_bound", 32'(waited < 8), 32'h1);
    repeat (40) cyc_step();

    // Backpressure: FIFO saturates, requests stop, then resume without loss
    out_rdy_pct = 0;
    repeat (12) cyc_step();
    @(negedge clk);
    check("full_count", 32'(bus.count), 32'(DEPTH));
    check("full_req_valid", 32'(bus.imem_req_valid), 32'h0);
    out_rdy_pct = 100;
    repeat (20) cyc_step();

    // Redirect with requests in flight (latency 3)
    lat_min = 3; lat_max = 3;
    repeat (10) cyc_step();
    cyc_step(1'b0, 1'b1, 32'h0000_0100);
    cyc_step();
    check_flushed("redir100");
    repeat (20) cyc_step();

    // Redirect coincident with a response and a pop while count==2
    lat_min = 2; lat_max = 3; out_rdy_pct = 50;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step_mem();
      if (bus.imem_rsp_valid && bus.count == CW'(2)) begin
        bus.out_ready = 1'b1;
        apply_ctrl(1'b0, 1'b1, 32'h0000_0040);
        found = 1'b1;
      end else begin
        apply_ctrl(1'b0, 1'b0, 32'h0);
      end
    end
    check("coincident_setup_found", 32'(found), 32'h1);
    cyc_step();
    check_flushed("redir40");
    out_rdy_pct = 100;
    repeat (20) cyc_step();

    // Back-to-back redirects
    lat_min = 2; lat_max = 2;
    cyc_step(1'b0, 1'b1, 32'h0000_0200);
    cyc_step(1'b0, 1'b1, 32'h0000_0300);
    cyc_step();
    check_flushed("redir300");
    repeat (30) cyc_step();

    // Address wrap with random stalls
    lat_min = 1; lat_max = 3; req_rdy_pct = 60; out_rdy_pct = 60;
    cyc_step(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (200) cyc_step();

    // Long random run with random redirects and a mid-run reset pulse
    lat_min = 1; lat_max = 4; req_rdy_pct = 70; out_rdy_pct = 70;
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        cyc_step(1'b1);
        cyc_step(1'b1);
        @(negedge clk);
        check_reset("midrun_reset");
      end else begin
        redir = ($urandom_range(63, 0) == 0);
        tgt   = $urandom & 32'hFFFF_FFFC;
        cyc_step(1'b0, redir, tgt);
      end
    end

    // Drain: steady state must deliver about one instruction per cycle
    lat_min = 1; lat_max = 1; req_rdy_pct = 100; out_rdy_pct = 100;
    cyc_step();
    p0 = pops;
    repeat (40) cyc_step();
    @(negedge clk);
    check("drain_progress", 32'((pops - p0) >= 30), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
